// File: rtl/c3lib_sync_level_qualify.sv
// c3lib_sync_level_qualify
//   Single-bit level qualifier for the output of a 2-stage synchronizer.
//   data_out follows data_in only after the new level has been sampled on
//   QUAL_CYCLES consecutive clk edges. Each qualified edge produces a
//   one-cycle rise_pls/fall_pls pulse.
//   Optional macro C3LIB_SYNC_LEVEL_QUALIFY_GLITCH_CNT_EN adds a saturating
//   count of aborted qualifications on glitch_cnt. Without the macro,
//   glitch_cnt is tied to zero.
module c3lib_sync_level_qualify #(
  parameter int   QUAL_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0,
  localparam int  CNT_W       = $clog2(QUAL_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic       data_out,
  output logic       rise_pls,
  output logic       fall_pls,
  output logic       pend,
  output logic [7:0] glitch_cnt
);

  typedef enum logic {STABLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, rise_nxt, fall_nxt;

  // Next-state, counter and transition decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = data_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (data_in != data_out) begin
          if (QUAL_CYCLES == 1) begin
            // Degenerates to a registered pass-through
            out_nxt  = data_in;
            rise_nxt = data_in;
            fall_nxt = ~data_in;
          end else begin
            state_nxt = PEND;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PEND: begin
        if (data_in == data_out) begin
          // Level fell back before qualifying: drop it
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          out_nxt   = data_in;
          rise_nxt  = data_in;
          fall_nxt  = ~data_in;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STABLE;
      cnt      <= '0;
      data_out <= RESET_VAL;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_out <= out_nxt;
      rise_pls <= rise_nxt;
      fall_pls <= fall_nxt;
    end
  end

  assign pend = (state == PEND);

`ifdef C3LIB_SYNC_LEVEL_QUALIFY_GLITCH_CNT_EN
  logic abort;
  assign abort = (state == PEND) && (data_in == data_out);

  // Saturating abort counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      glitch_cnt <= 8'h00;
    else if (abort && (glitch_cnt != 8'hFF))
      glitch_cnt <= glitch_cnt + 8'd1;
  end
`else
  assign glitch_cnt = 8'h00;
`endif

endmodule
